// File: rtl/fp_pkg.sv
// Shared constants, FSM state type for the sequential single-precision divider.
package fp_pkg;
  localparam int          FP_BIAS  = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam int          DIV_ITER = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } fp_state_t;
endpackage

// File: rtl/fp_classify.sv
// Combinational decode of one single-precision operand; exponent 0 is flushed to zero.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] op,
  output logic        is_zero,
  output logic        is_infnan,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] mant24
);
  assign sign      = op[31];
  assign exp       = op[30:23];
  assign is_zero   = (op[30:23] == 8'h00);
  assign is_infnan = (op[30:23] == 8'(EXP_MAX));
  assign mant24    = {1'b1, op[22:0]};
endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider: restoring division, one quotient bit per cycle,
// truncating, fixed 27-cycle latency from accepted start to done.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_dz,
  output logic        flag_inv,
  output logic        flag_ovf,
  output logic        flag_unf
);
  logic        za, zb, nana, nanb, sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  fp_classify u_cls_a (.op(a), .is_zero(za), .is_infnan(nana), .sign(sa), .exp(ea), .mant24(ma));
  fp_classify u_cls_b (.op(b), .is_zero(zb), .is_infnan(nanb), .sign(sb), .exp(eb), .mant24(mb));

  fp_state_t   state;
  logic        sign_r, za_r, zb_r, inv_r;
  logic [7:0]  ea_r, eb_r;
  logic [23:0] mb_r;
  logic [24:0] rem, q;
  logic [4:0]  cnt;

  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;
  logic [31:0]       res_n;
  logic [3:0]        fl_n;   // {dz, inv, ovf, unf}

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  always_comb begin
    // q[24] set means the mantissa ratio was >= 1, so one less exponent decrement
    exp_n  = $signed(10'(ea_r)) - $signed(10'(eb_r)) + $signed(10'(FP_BIAS))
             - (q[24] ? 10'sd0 : 10'sd1);
    frac_n = q[24] ? q[23:1] : q[22:0];
    res_n  = {sign_r, exp_n[7:0], frac_n};
    fl_n   = 4'b0000;
    if (inv_r || (za_r && zb_r)) begin
      res_n = QNAN;
      fl_n  = 4'b0100;
    end else if (zb_r) begin
      res_n = {sign_r, 8'(EXP_MAX), 23'h0};
      fl_n  = 4'b1000;
    end else if (za_r) begin
      res_n = {sign_r, 31'h0};
    end else if (exp_n >= $signed(10'(EXP_MAX))) begin
      res_n = {sign_r, 8'(EXP_MAX), 23'h0};
      fl_n  = 4'b0010;
    end else if (exp_n <= 10'sd0) begin
      res_n = {sign_r, 31'h0};
      fl_n  = 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result   <= 32'h0;
      flag_dz  <= 1'b0;
      flag_inv <= 1'b0;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      sign_r   <= 1'b0;
      za_r     <= 1'b0;
      zb_r     <= 1'b0;
      inv_r    <= 1'b0;
      ea_r     <= 8'h0;
      eb_r     <= 8'h0;
      mb_r     <= 24'h0;
      rem      <= 25'h0;
      q        <= 25'h0;
      cnt      <= 5'h0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          sign_r <= sa ^ sb;
          za_r   <= za;
          zb_r   <= zb;
          inv_r  <= nana | nanb;
          ea_r   <= ea;
          eb_r   <= eb;
          mb_r   <= mb;
          rem    <= {1'b0, ma};
          q      <= 25'h0;
          cnt    <= 5'h0;
          state  <= ST_DIV;
        end
        ST_DIV: begin
          if (rem >= {1'b0, mb_r}) begin
            q   <= {q[23:0], 1'b1};
            rem <= (rem - {1'b0, mb_r}) << 1;
          end else begin
            q   <= {q[23:0], 1'b0};
            rem <= rem << 1;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITER - 1)) state <= ST_NORM;
        end
        ST_NORM: begin
          result   <= res_n;
          flag_dz  <= fl_n[3];
          flag_inv <= fl_n[2];
          flag_ovf <= fl_n[1];
          flag_unf <= fl_n[0];
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed table, reset/re-start corner sequences, random ops vs arithmetic model.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a, b, result;
  logic        ready, done, flag_dz, flag_inv, flag_ovf, flag_unf;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_res;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .result(result),
    .flag_dz(flag_dz), .flag_inv(flag_inv), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;   // {dz, inv, ovf, unf}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    int ea, eb, e;
    logic s;
    longint ma, mb, qq;
    logic [22:0] frac;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    s  = x[31] ^ y[31];
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) return {4'b0100, 32'h7FC00000};
    if (eb == 0) return {4'b1000, s, 8'hFF, 23'h0};
    if (ea == 0) return {4'b0000, s, 31'h0};
    ma = longint'({1'b1, x[22:0]});
    mb = longint'({1'b1, y[22:0]});
    qq = (ma << 24) / mb;
    if (qq >= (64'd1 << 24)) begin
      frac = qq[23:1];
      e = ea - eb + 127;
    end else begin
      frac = qq[22:0];
      e = ea - eb + 126;
    end
    if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0001, s, 31'h0};
    return {4'b0000, s, e[7:0], frac};
  endfunction

  // Entered at a negedge; leaves at the negedge of cycle 28 with start low.
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] er, input logic [3:0] ef,
                       input bit disturb, input string tag);
    int k;
    int lat;
    for (int w = 0; w < 40 && !ready; w++) @(negedge clk);
    chk({tag, " ready_before"}, 32'(ready), 32'd1);
    start = 1'b1; a = xa; b = xb;
    lat = -1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; a = $urandom; b = $urandom; end
      if (disturb && k == 5) begin start = 1'b1; a = 32'h3F800000; b = 32'h40400000; end
      if (disturb && k == 6) start = 1'b0;
      if (k == 10) chk({tag, " held_result"}, result, prev_res);
      if (done) begin lat = k; break; end
    end
    chk({tag, " latency"}, 32'(lat), 32'd27);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, {28'h0, flag_dz, flag_inv, flag_ovf, flag_unf}, {28'h0, ef});
    prev_res = er;
    @(negedge clk);
    chk({tag, " ready_c28"}, {30'h0, ready, done}, 32'd2);
    chk({tag, " hold_c28"}, result, er);
  endtask

  vec_t vecs[13];
  logic [35:0] m;
  logic [31:0] ra, rb;
  int seen_done;

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000};
    vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1000};
    vecs[3]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010};
    vecs[4]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001};
    vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0100};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 4'b0100};
    vecs[7]  = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 4'b0100};
    vecs[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
    vecs[9]  = '{32'h00000001, 32'hBF800000, 32'h80000000, 4'b0000};
    vecs[10] = '{32'h3F800000, 32'h00000005, 32'h7F800000, 4'b1000};
    vecs[11] = '{32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000};
    vecs[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};

    // Reset with start held high: start must be ignored.
    rst_n = 1'b0; start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
    prev_res = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset ready_done", {30'h0, ready, done}, 32'd2);
    chk("reset result", result, 32'h0);
    chk("reset flags", {28'h0, flag_dz, flag_inv, flag_ovf, flag_unf}, 32'h0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("start_in_reset ignored", {31'h0, ready}, 32'd1);

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, 1'b0, $sformatf("vec%0d", i));

    // Re-pulsed start mid-operation, then immediate back-to-back start in cycle 28.
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1, "restart_ignored");
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 1'b0, "start_c28");

    // Reset in cycle 10 of an operation aborts it.
    start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("abort ready_done", {30'h0, ready, done}, 32'd2);
    chk("abort result", result, 32'h0);
    rst_n = 1'b1; start = 1'b0;
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort no_done", 32'(seen_done), 32'd0);
    prev_res = 32'h0;
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0, "after_abort");

    // Random operands against the arithmetic model.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      m = ref_div(ra, rb);
      do_op(ra, rb, m[31:0], m[35:32], 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at IEEE-754 single precision (32-bit).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request; SHALL be accepted only when ready=1.
REQ-005 a  input  32  dividend, IEEE-754 single.
REQ-006 b  input  32  divisor, IEEE-754 single.
REQ-007 ready  output  1  SHALL be 1 when in IDLE, 0 otherwise.
REQ-008 done  output  1  one-cycle pulse; result and flags are valid in that cycle.
REQ-009 result  output  32  quotient a/b.
REQ-010 flag_dz  output  1  divide by zero (a nonzero finite, b zero).
REQ-011 flag_inv  output  1  invalid: 0/0, or any operand with exponent field 255.
REQ-012 flag_ovf  output  1  result exponent overflow.
REQ-013 flag_unf  output  1  result exponent underflow.

Function
REQ-014 The FSM SHALL have states IDLE, DIV, NORM and DONE: IDLE->DIV on accepted start; DIV->NORM after 25 iterations; NORM->DONE; DONE->IDLE unconditionally.
REQ-015 On an accepted start, a and b SHALL be latched; later changes to a and b SHALL have no effect on the operation in flight.
REQ-016 start while ready=0 SHALL be ignored, with no queuing.
REQ-017 Latency SHALL be fixed: start sampled in cycle 0 -> done=1 in cycle 27, and ready=1 again in cycle 28. Special cases SHALL use the same latency.
REQ-018 Mantissas SHALL be 24 bits wide, with the hidden 1 restored.
REQ-019 Restoring division SHALL run one quotient bit per DIV cycle, MSB first:
- 25-bit remainder initialised to mantissa(a);
- if rem >= mantissa(b): bit=1 and rem -= mantissa(b);
- then rem <<= 1.
REQ-020 In NORM, if q[24]=1 then frac=q[23:1] and exp=ea-eb+127; otherwise frac=q[22:0] and exp=ea-eb+126. Exponent arithmetic SHALL be 10-bit signed.
REQ-021 Rounding SHALL be truncation only; the remainder SHALL be discarded.
REQ-022 sign SHALL be a[31]^b[31] for all results except NaN.
REQ-023 exp >= 255 SHALL give result {sign,8'hFF,23'h0} with flag_ovf=1.
REQ-024 exp <= 0 SHALL give result {sign,31'h0} with flag_unf=1. Denormals SHALL NOT be produced.
REQ-025 An operand with exponent field 0 SHALL be treated as zero, since denormal inputs are flushed.
REQ-026 Special-case priority SHALL be as follows:
- any exponent field 255, or a=0 and b=0: result 32'h7FC00000, flag_inv=1;
- else b=0: result {sign,8'hFF,23'h0}, flag_dz=1;
- else a=0: result {sign,31'h0}, no flag.
REQ-027 result and the flags SHALL hold their values after done until the next done. All flags of the next operation SHALL be written together with its result.
REQ-028 At most one flag SHALL be 1 per operation.

Reset
REQ-029 While rst_n=0 at a clock edge:
- the state SHALL go to IDLE;
- done, result and all flags SHALL be 0;
- ready SHALL be 1 from the following cycle.
REQ-030 A reset during DIV, NORM or DONE SHALL abort the operation, and no done SHALL follow.
REQ-031 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-032 Package fp_pkg SHALL hold the shared constants and types:
- FP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, DIV_ITER=25;
- the FSM state enum.
REQ-033 A combinational sub-module fp_classify SHALL decode a 32-bit operand into is_zero, is_infnan, sign, exp and mant24. It SHALL be instantiated twice, once for a and once for b.
REQ-034 The quotient, remainder and iteration counter SHALL be registers local to fp_div_seq.

Verification
REQ-035 a=32'h40C00000, b=32'h40000000 -> result 32'h40400000 at cycle 27, no flags.
REQ-036 a=32'h3F800000, b=32'h40400000 -> result 32'h3EAAAAAA (truncated), no flags.
REQ-037 a=32'hBF800000, b=32'h00000000 -> result 32'hFF800000, flag_dz=1, at cycle 27.
REQ-038 a=32'h7F000000, b=32'h3E800000 -> result 32'h7F800000, flag_ovf=1. Separately, a=32'h00800000, b=32'h40000000 -> result 32'h00000000, flag_unf=1.
REQ-039 start re-pulsed in cycle 5 with different operands -> ignored; the cycle-27 result matches the first operands; a start in cycle 28 is accepted.
REQ-040 rst_n=0 in cycle 10 of an operation -> no done, result 0, ready=1 in cycle 11; a new operation then completes normally.
